// File: rtl/ud_count_ctrl_if.sv
// Command/status bundle for the bounded up/down count controller.
// The slave side is the controller; the master side is the surrounding sequencer.
interface ud_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] count;
  logic             ud;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start, stop, pause, mode, lo, hi,
    input  count, ud, busy, done, err
  );

  modport slave (
    input  start, stop, pause, mode, lo, hi,
    output count, ud, busy, done, err
  );
endinterface

// File: rtl/ud_count_ctrl.sv
// Bounded, commandable up/down counter: steps COUNT between latched LO/HI bounds
// in one-shot, ping-pong or wrap mode, with stop/pause control and done/err pulses.
//
// state      | meaning
// -----------+------------------------------------------------------------
// S_IDLE     | waiting for START; COUNT/UD hold their last values
// S_RUN_UP   | stepping COUNT upward towards HI
// S_RUN_DOWN | stepping COUNT downward towards LO
// S_PAUSED   | frozen; resume_up_q holds the run direction to return to
module ud_count_ctrl #(
  parameter int WIDTH = 4
) (
  input logic            clk,
  input logic            rst,
  ud_count_ctrl_if.slave bus_if
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN_UP   = 2'd1,
    S_RUN_DOWN = 2'd2,
    S_PAUSED   = 2'd3
  } state_t;

  localparam logic [1:0]       M_UP   = 2'b00;
  localparam logic [1:0]       M_DOWN = 2'b01;
  localparam logic [1:0]       M_PING = 2'b10;
  localparam logic [1:0]       M_WRAP = 2'b11;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [1:0]       mode_q, mode_d;
  logic             ud_q, ud_d;
  logic             resume_up_q, resume_up_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             dir_up;
  state_t           step_state;
  logic [WIDTH-1:0] step_count;
  logic             step_ud;
  logic             step_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      lo_q        <= '0;
      hi_q        <= '0;
      mode_q      <= M_UP;
      ud_q        <= 1'b1;
      resume_up_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      mode_q      <= mode_d;
      ud_q        <= ud_d;
      resume_up_q <= resume_up_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  // One count step in the active direction; shared by the run states and by
  // the resume edge out of S_PAUSED, so a pause costs exactly its own cycles.
  assign dir_up = (state_q == S_RUN_UP) || ((state_q == S_PAUSED) && resume_up_q);

  always_comb begin
    step_state = dir_up ? S_RUN_UP : S_RUN_DOWN;
    step_count = count_q;
    step_ud    = dir_up;
    step_done  = 1'b0;
    if (dir_up) begin
      if (count_q != hi_q) begin
        step_count = count_q + ONE;
      end else begin
        case (mode_q)
          M_WRAP: begin
            step_count = lo_q;
            step_done  = 1'b1;
          end
          M_PING: begin
            step_state = S_RUN_DOWN;
            step_ud    = 1'b0;
            if (lo_q != hi_q) step_count = hi_q - ONE;
          end
          default: begin
            step_state = S_IDLE;
            step_done  = 1'b1;
          end
        endcase
      end
    end else begin
      if (count_q != lo_q) begin
        step_count = count_q - ONE;
      end else begin
        case (mode_q)
          M_PING: begin
            step_state = S_RUN_UP;
            step_ud    = 1'b1;
            step_done  = 1'b1;
            if (lo_q != hi_q) step_count = lo_q + ONE;
          end
          default: begin
            step_state = S_IDLE;
            step_done  = 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    mode_d      = mode_q;
    ud_d        = ud_q;
    resume_up_d = resume_up_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!bus_if.stop && bus_if.start) begin
          if (bus_if.lo > bus_if.hi) begin
            err_d = 1'b1;
          end else begin
            lo_d   = bus_if.lo;
            hi_d   = bus_if.hi;
            mode_d = bus_if.mode;
            if (bus_if.mode == M_DOWN) begin
              count_d = bus_if.hi;
              ud_d    = 1'b0;
              state_d = S_RUN_DOWN;
            end else begin
              count_d = bus_if.lo;
              ud_d    = 1'b1;
              state_d = S_RUN_UP;
            end
          end
        end
      end

      S_RUN_UP, S_RUN_DOWN: begin
        if (bus_if.stop) begin
          state_d = S_IDLE;
        end else if (bus_if.pause) begin
          state_d     = S_PAUSED;
          resume_up_d = (state_q == S_RUN_UP);
        end else begin
          state_d = step_state;
          count_d = step_count;
          ud_d    = step_ud;
          done_d  = step_done;
        end
      end

      S_PAUSED: begin
        if (bus_if.stop) begin
          state_d = S_IDLE;
        end else if (!bus_if.pause) begin
          state_d = step_state;
          count_d = step_count;
          ud_d    = step_ud;
          done_d  = step_done;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus_if.count = count_q;
  assign bus_if.ud    = ud_q;
  assign bus_if.busy  = (state_q != S_IDLE);
  assign bus_if.done  = done_q;
  assign bus_if.err   = err_q;

endmodule

// File: tb/tb_ud_count_ctrl.sv
// Scoreboard bench for ud_count_ctrl: a trajectory-queue reference model predicts
// every post-edge output; a monitor compares the DUT one step after each edge.
module tb_ud_count_ctrl;

  typedef struct packed {
    logic [3:0] count;
    logic       ud;
    logic       busy;
    logic       done;
    logic       err;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ud_count_ctrl_if #(.WIDTH(4)) bus ();

  ud_count_ctrl #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  out_t exp_q[$];

  // Reference model: an accepted START expands into the list of outputs the
  // sequence will show; repeating modes append one period at a time.
  out_t traj[$];
  out_t cur;
  int   m_lo, m_hi;
  logic [1:0] m_mode;
  bit   pp_first;

  function automatic out_t mk(int c, logic u, logic b, logic d);
    out_t r;
    r.count = 4'(c);
    r.ud    = u;
    r.busy  = b;
    r.done  = d;
    r.err   = 1'b0;
    return r;
  endfunction

  task automatic model_reset();
    traj.delete();
    cur = mk(0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic build();
    case (m_mode)
      2'b00: begin
        for (int v = m_lo; v <= m_hi; v++) traj.push_back(mk(v, 1'b1, 1'b1, 1'b0));
        traj.push_back(mk(m_hi, 1'b1, 1'b0, 1'b1));
      end
      2'b01: begin
        for (int v = m_hi; v >= m_lo; v--) traj.push_back(mk(v, 1'b0, 1'b1, 1'b0));
        traj.push_back(mk(m_lo, 1'b0, 1'b0, 1'b1));
      end
      default: begin
        traj.push_back(mk(m_lo, 1'b1, 1'b1, 1'b0));
        pp_first = 1'b1;
      end
    endcase
  endtask

  task automatic refill();
    if (m_mode == 2'b11) begin
      for (int v = m_lo + 1; v <= m_hi; v++) traj.push_back(mk(v, 1'b1, 1'b1, 1'b0));
      traj.push_back(mk(m_lo, 1'b1, 1'b1, 1'b1));
    end else begin
      for (int v = (pp_first ? m_lo + 1 : m_lo + 2); v <= m_hi; v++)
        traj.push_back(mk(v, 1'b1, 1'b1, 1'b0));
      if (m_lo < m_hi)
        for (int v = m_hi - 1; v >= m_lo; v--) traj.push_back(mk(v, 1'b0, 1'b1, 1'b0));
      else
        traj.push_back(mk(m_lo, 1'b0, 1'b1, 1'b0));
      traj.push_back(mk((m_lo < m_hi) ? m_lo + 1 : m_lo, 1'b1, 1'b1, 1'b1));
      pp_first = 1'b0;
    end
  endtask

  task automatic model_step(input logic st, input logic sp, input logic pa,
                            input logic [1:0] md, input logic [3:0] l,
                            input logic [3:0] h, output out_t o);
    o      = cur;
    o.done = 1'b0;
    o.err  = 1'b0;
    if (!cur.busy) begin
      if (!sp && st) begin
        if (l > h) begin
          o.err = 1'b1;
        end else begin
          m_lo   = int'(l);
          m_hi   = int'(h);
          m_mode = md;
          traj.delete();
          build();
          o = traj.pop_front();
        end
      end
    end else if (sp) begin
      o.busy = 1'b0;
      traj.delete();
    end else if (!pa) begin
      if (traj.size() == 0) refill();
      o = traj.pop_front();
    end
    cur = o;
  endtask

  task automatic drive(input logic st, input logic sp, input logic pa,
                       input logic [1:0] md, input logic [3:0] l, input logic [3:0] h);
    out_t o;
    @(negedge clk);
    bus.start = st;
    bus.stop  = sp;
    bus.pause = pa;
    bus.mode  = md;
    bus.lo    = l;
    bus.hi    = h;
    model_step(st, sp, pa, md, l, h, o);
    exp_q.push_back(o);
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 4'd0);
  endtask

  task automatic check_direct(input string name, input out_t want);
    out_t got;
    got.count = bus.count;
    got.ud    = bus.ud;
    got.busy  = bus.busy;
    got.done  = bus.done;
    got.err   = bus.err;
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got count=%0d ud=%b busy=%b done=%b err=%b, expected count=%0d ud=%b busy=%b done=%b err=%b",
               name, got.count, got.ud, got.busy, got.done, got.err,
               want.count, want.ud, want.busy, want.done, want.err);
    end
  endtask

  // Monitor: the controller presents a fresh output every cycle.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        out_t e;
        e = exp_q.pop_front();
        check_direct($sformatf("cycle%0d", cyc), e);
      end
    end
  end

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.pause = 1'b0;
    bus.mode  = 2'b00;
    bus.lo    = 4'd0;
    bus.hi    = 4'd0;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    check_direct("reset_state", mk(0, 1'b1, 1'b0, 1'b0));
    rst = 1'b0;

    // One-shot up 3..6 with a START while busy that must be ignored.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd3, 4'd6);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd15);
    idle_cyc(6);

    // Full-range ping-pong, two complete periods plus the initial climb.
    drive(1'b1, 1'b0, 1'b0, 2'b10, 4'd0, 4'd15);
    idle_cyc(76);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);

    // Wrap-up 2..4, stopped at COUNT = 3.
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'd2, 4'd4);
    idle_cyc(4);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    idle_cyc(2);

    // Down mode paused at 9 for three cycles, then STOP+PAUSE together.
    drive(1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 4'd12);
    idle_cyc(3);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0);
    idle_cyc(2);
    drive(1'b0, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0);
    idle_cyc(1);

    // Rejection, START beaten by STOP, degenerate one-shot down.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd7, 4'd2);
    idle_cyc(2);
    drive(1'b1, 1'b1, 1'b0, 2'b00, 4'd1, 4'd9);
    idle_cyc(2);
    drive(1'b1, 1'b0, 1'b0, 2'b01, 4'd5, 4'd5);
    idle_cyc(3);

    // Repeating modes with LO == HI.
    drive(1'b1, 1'b0, 1'b0, 2'b10, 4'd8, 4'd8);
    idle_cyc(5);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 2'b11, 4'd15, 4'd15);
    idle_cyc(3);
    drive(1'b0, 1'b1, 1'b0, 2'b00, 4'd0, 4'd0);

    // Asynchronous reset while counting up at 5.
    drive(1'b1, 1'b0, 1'b0, 2'b00, 4'd2, 4'd9);
    idle_cyc(3);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_direct("async_reset_mid_run", mk(0, 1'b1, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       st, sp, pa;
      logic [1:0] md;
      logic [3:0] l, h;
      st = ($urandom_range(0, 5) == 0);
      sp = ($urandom_range(0, 39) == 0);
      pa = ($urandom_range(0, 9) == 0);
      md = 2'($urandom_range(0, 3));
      l  = 4'($urandom_range(0, 15));
      h  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0 && l > h) begin
        logic [3:0] t;
        t = l;
        l = h;
        h = t;
      end
      drive(st, sp, pa, md, l, h);
    end

    idle_cyc(2);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expected outputs never compared, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
